// File: rtl/scr1_tb_ahb_mem_mport_if.sv
// AHB-Lite bus bundle for the multi-port memory model: one slot per slave port.
interface scr1_tb_ahb_mem_mport_if #(parameter int NPORTS = 2);
    logic [NPORTS-1:0][1:0]  htrans;
    logic [NPORTS-1:0][2:0]  hsize;
    logic [NPORTS-1:0][31:0] haddr;
    logic [NPORTS-1:0]       hwrite;
    logic [NPORTS-1:0][31:0] hwdata;
    logic [NPORTS-1:0]       hready;
    logic [NPORTS-1:0]       hresp;
    logic [NPORTS-1:0][31:0] hrdata;

    modport master (output htrans, hsize, haddr, hwrite, hwdata,
                    input  hready, hresp, hrdata);
    modport slave  (input  htrans, hsize, haddr, hwrite, hwdata,
                    output hready, hresp, hrdata);
endinterface

// File: rtl/scr1_tb_ahb_mem_mport.sv
// Multi-port AHB-Lite slave memory model: per-port wait/error FSMs over one shared word array.
module scr1_tb_ahb_mem_mport_port #(
    parameter int          DEPTH_LOG2 = 18,
    parameter logic [31:0] ERR_BASE   = 32'hFFFF_0000,
    parameter logic [31:0] ERR_MASK   = 32'hFFFF_0000,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            stall_mode,
    input  logic [3:0]            stall_val,
    input  logic [1:0]            htrans,
    input  logic [2:0]            hsize,
    input  logic [31:0]           haddr,
    input  logic                  hwrite,
    output logic                  hready,
    output logic                  hresp,
    output logic                  wr_done,
    output logic                  rd_done,
    output logic [3:0]            be,
    output logic [DEPTH_LOG2-1:0] idx
);
    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt, wait_w;
    logic [15:0]           lfsr;
    logic [2:0]            size_q;
    logic [1:0]            alo_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic                  wr_q;
    logic                  accept, err_in, done;

    assign hready = (state == IDLE) || (state == ERR2) || (state == DATA && cnt == 4'd0);
    assign hresp  = (state == ERR1) || (state == ERR2);
    assign accept = htrans[1] && hready;
    assign done   = (state == DATA) && (cnt == 4'd0);

    assign err_in = ((ERR_MASK != 32'd0) && ((haddr & ERR_MASK) == ERR_BASE))
                 || (hsize > 3'd2)
                 || (hsize == 3'd1 && haddr[0])
                 || (hsize == 3'd2 && haddr[1:0] != 2'd0);

    always_comb begin
        wait_w = 4'd0;
        case (stall_mode)
            2'd1:    wait_w = stall_val;
            2'd2:    wait_w = lfsr[3:0] & stall_val;
            default: wait_w = 4'd0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: ;
            DATA: if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
                  else             state_nxt = IDLE;
            ERR1: state_nxt = ERR2;
            ERR2: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A new address phase overrides the return to IDLE (back-to-back pipelining)
        if (accept) begin
            state_nxt = err_in ? ERR1 : DATA;
            cnt_nxt   = wait_w;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            lfsr   <= SEED;
            size_q <= 3'd0;
            alo_q  <= 2'd0;
            idx_q  <= '0;
            wr_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                size_q <= hsize;
                alo_q  <= haddr[1:0];
                idx_q  <= haddr[DEPTH_LOG2+1:2];
                wr_q   <= hwrite;
            end
            if (accept && stall_mode == 2'd2)
                lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    always_comb begin
        be = 4'b1111;
        case (size_q)
            3'd0:    be = 4'b0001 << alo_q;
            3'd1:    be = alo_q[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
    end

    assign wr_done = done && wr_q;
    assign rd_done = done && !wr_q;
    assign idx     = idx_q;
endmodule

module scr1_tb_ahb_mem_mport #(
    parameter int          NPORTS     = 2,
    parameter int          DEPTH_LOG2 = 18,
    parameter logic [31:0] ERR_BASE   = 32'hFFFF_0000,
    parameter logic [31:0] ERR_MASK   = 32'hFFFF_0000,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NPORTS-1:0][1:0] stall_mode,
    input  logic [NPORTS-1:0][3:0] stall_val,
    scr1_tb_ahb_mem_mport_if.slave bus
);
    logic [31:0]                        mem [0:(1<<DEPTH_LOG2)-1];
    logic [NPORTS-1:0]                  wr_done, rd_done;
    logic [NPORTS-1:0][3:0]             be;
    logic [NPORTS-1:0][DEPTH_LOG2-1:0]  idx;

    for (genvar p = 0; p < NPORTS; p++) begin : g_port
        scr1_tb_ahb_mem_mport_port #(
            .DEPTH_LOG2 (DEPTH_LOG2),
            .ERR_BASE   (ERR_BASE),
            .ERR_MASK   (ERR_MASK),
            .SEED       (LFSR_SEED ^ 16'(p))
        ) u_port (
            .clk        (clk),
            .rst        (rst),
            .stall_mode (stall_mode[p]),
            .stall_val  (stall_val[p]),
            .htrans     (bus.htrans[p]),
            .hsize      (bus.hsize[p]),
            .haddr      (bus.haddr[p]),
            .hwrite     (bus.hwrite[p]),
            .hready     (bus.hready[p]),
            .hresp      (bus.hresp[p]),
            .wr_done    (wr_done[p]),
            .rd_done    (rd_done[p]),
            .be         (be[p]),
            .idx        (idx[p])
        );

        // Combinational read sees the array before this edge's writes land
        assign bus.hrdata[p] = rd_done[p] ? mem[idx[p]] : 32'd0;
    end

    // Later loop iterations overwrite earlier ones: higher port index wins per byte lane
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NPORTS; p++)
                for (int b = 0; b < 4; b++)
                    if (wr_done[p] && be[p][b])
                        mem[idx[p]][8*b +: 8] <= bus.hwdata[p][8*b +: 8];
        end
    end
endmodule

// File: tb/tb_scr1_tb_ahb_mem_mport.sv
// Directed bench for the multi-port AHB memory model with a per-port expected-response scoreboard.
module tb_scr1_tb_ahb_mem_mport;
    localparam int NP = 2;
    localparam int DL = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NP-1:0][1:0] stall_mode;
    logic [NP-1:0][3:0] stall_val;

    always #5 clk = ~clk;

    scr1_tb_ahb_mem_mport_if #(.NPORTS(NP)) bus ();

    scr1_tb_ahb_mem_mport #(.NPORTS(NP), .DEPTH_LOG2(DL)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_mode (stall_mode),
        .stall_val  (stall_val),
        .bus        (bus)
    );

    typedef struct {
        logic        wr;
        logic        err;
        int          waits;
        logic [31:0] data;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        cur [NP];
    bit          cur_v [NP];
    int          lowc [NP];
    logic [31:0] model [int];
    logic [15:0] lfsr_m [NP];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [2:0] sz, input logic [1:0] lo);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) begin
            if (sz == 3'd2 || (sz == 3'd1 && (b / 2) == int'(lo[1])) || (sz == 3'd0 && b == int'(lo)))
                r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    // Record what the DUT must answer for an address phase about to be driven
    task automatic push(input int p, input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        exp_t e;
        int   key = int'(a[DL+1:2]);
        int   w = 0;
        logic err = (a[31:16] == 16'hFFFF) || (sz > 3'd2) || (sz == 3'd1 && a[0])
                 || (sz == 3'd2 && a[1:0] != 2'd0);
        if (stall_mode[p] == 2'd1) w = int'(stall_val[p]);
        if (stall_mode[p] == 2'd2) begin
            w = int'(lfsr_m[p][3:0] & stall_val[p]);
            lfsr_m[p] = lfsr_next(lfsr_m[p]);
        end
        e.wr = wr;
        e.err = err;
        e.waits = err ? 1 : w;
        e.data = (!wr && !err) ? model[key] : 32'd0;
        if (wr && !err)
            model[key] = merge(model.exists(key) ? model[key] : 32'd0, wd, sz, a[1:0]);
        if (p == 0) q0.push_back(e); else q1.push_back(e);
    endtask

    task automatic drive_addr(input int p, input bit wr, input logic [2:0] sz, input logic [31:0] a);
        bus.htrans[p] = 2'b10;
        bus.hwrite[p] = wr;
        bus.hsize[p]  = sz;
        bus.haddr[p]  = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single non-pipelined transfer on one port, bounded wait for completion
    task automatic xfer(input int p, input bit wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        push(p, wr, sz, a, wd);
        drive_addr(p, wr, sz, a);
        step();
        bus.htrans[p] = 2'b00;
        bus.hwdata[p] = wd;
        while (!bus.hready[p] && n < 40) begin
            step();
            n++;
        end
        checks++;
        assert (n < 40) else begin
            failures++;
            $error("FAIL xfer_timeout port=%0d waited=%0d limit=40", p, n);
        end
        step();
    endtask

    // Two transfers issued on ports 0 and 1 in the same cycle, both zero-wait
    task automatic dual(input bit w0, input logic [2:0] s0, input logic [31:0] a0, input logic [31:0] d0,
                        input bit w1, input logic [2:0] s1, input logic [31:0] a1, input logic [31:0] d1);
        push(0, w0, s0, a0, d0);
        push(1, w1, s1, a1, d1);
        drive_addr(0, w0, s0, a0);
        drive_addr(1, w1, s1, a1);
        step();
        bus.htrans[0] = 2'b00;
        bus.htrans[1] = 2'b00;
        bus.hwdata[0] = d0;
        bus.hwdata[1] = d1;
        chk("dual_hready", 32'(bus.hready), 32'h3);
        step();
    endtask

    // Scoreboard: completion checks, then pop on each accepted address phase
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            exp_t e;
            bit   have;
            if (rst) begin
                cur_v[p] = 1'b0;
                lowc[p] = 0;
            end else begin
                if (cur_v[p]) begin
                    if (!bus.hready[p]) begin
                        lowc[p]++;
                    end else begin
                        chk($sformatf("p%0d_waits", p), 32'(lowc[p]), 32'(cur[p].waits));
                        chk($sformatf("p%0d_hresp", p), 32'(bus.hresp[p]), 32'(cur[p].err));
                        chk($sformatf("p%0d_hrdata", p), bus.hrdata[p], cur[p].data);
                        cur_v[p] = 1'b0;
                    end
                end
                if (bus.htrans[p][1] && bus.hready[p]) begin
                    have = (p == 0) ? (q0.size() != 0) : (q1.size() != 0);
                    chk($sformatf("p%0d_accept_expected", p), 32'(have), 32'd1);
                    if (have) begin
                        if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
                        cur[p] = e;
                        cur_v[p] = 1'b1;
                        lowc[p] = 0;
                    end
                end
            end
        end
    end

    initial begin
        bus.htrans = '0;
        bus.hsize  = '0;
        bus.haddr  = '0;
        bus.hwrite = '0;
        bus.hwdata = '0;
        stall_mode = '0;
        stall_val  = '0;
        for (int p = 0; p < NP; p++) lfsr_m[p] = 16'hACE1 ^ 16'(p);

        rst = 1'b1;
        repeat (3) step();
        chk("rst_hready", 32'(bus.hready), 32'h3);
        chk("rst_hresp", 32'(bus.hresp), 32'h0);
        chk("rst_hrdata0", bus.hrdata[0], 32'h0);
        chk("rst_hrdata1", bus.hrdata[1], 32'h0);
        rst = 1'b0;
        step();

        // Zero-wait write then pipelined read of the same word
        push(0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF);
        drive_addr(0, 1'b1, 3'd2, 32'h100);
        step();
        chk("t1_wr_dphase_hready", 32'(bus.hready[0]), 32'd1);
        push(0, 1'b0, 3'd2, 32'h100, 32'h0);
        drive_addr(0, 1'b0, 3'd2, 32'h100);
        bus.hwdata[0] = 32'hDEADBEEF;
        step();
        bus.htrans[0] = 2'b00;
        chk("t1_rd_dphase_hready", 32'(bus.hready[0]), 32'd1);
        chk("t1_rd_hrdata", bus.hrdata[0], 32'hDEADBEEF);
        step();

        // BUSY is ignored
        bus.htrans[0] = 2'b01;
        bus.haddr[0] = 32'h100;
        step();
        chk("busy_hready", 32'(bus.hready[0]), 32'd1);
        chk("busy_hresp", 32'(bus.hresp[0]), 32'd0);
        chk("busy_hrdata", bus.hrdata[0], 32'd0);
        bus.htrans[0] = 2'b00;
        step();

        // Fixed three wait states
        stall_mode[0] = 2'd1;
        stall_val[0] = 4'd3;
        xfer(0, 1'b0, 3'd2, 32'h100, 32'h0);
        stall_mode[0] = 2'd0;

        // Byte lanes, misaligned and oversize errors, aliasing
        xfer(0, 1'b1, 3'd2, 32'h100, 32'h11223344);
        xfer(0, 1'b1, 3'd0, 32'h103, 32'hAA000000);
        xfer(0, 1'b0, 3'd2, 32'h100, 32'h0);
        xfer(0, 1'b1, 3'd1, 32'h101, 32'h55660000);
        xfer(0, 1'b1, 3'd3, 32'h100, 32'h0);
        xfer(0, 1'b0, 3'd2, 32'h100, 32'h0);
        xfer(0, 1'b1, 3'd1, 32'h102, 32'hBEEF0000);
        xfer(1, 1'b1, 3'd0, 32'h104 + (32'h1 << 20), 32'h00007700);
        xfer(0, 1'b0, 3'd2, 32'h100, 32'h0);
        xfer(0, 1'b0, 3'd2, 32'h104, 32'h0);

        // Error window: ERR1 then ERR2, with next transfer accepted in ERR2
        push(0, 1'b0, 3'd2, 32'hFFFF_0010, 32'h0);
        drive_addr(0, 1'b0, 3'd2, 32'hFFFF_0010);
        step();
        bus.htrans[0] = 2'b00;
        chk("err1_hready", 32'(bus.hready[0]), 32'd0);
        chk("err1_hresp", 32'(bus.hresp[0]), 32'd1);
        step();
        chk("err2_hready", 32'(bus.hready[0]), 32'd1);
        chk("err2_hresp", 32'(bus.hresp[0]), 32'd1);
        push(0, 1'b0, 3'd2, 32'h100, 32'h0);
        drive_addr(0, 1'b0, 3'd2, 32'h100);
        step();
        bus.htrans[0] = 2'b00;
        chk("after_err_hresp", 32'(bus.hresp[0]), 32'd0);
        step();

        // Same-cycle collisions between ports
        dual(1'b1, 3'd2, 32'h200, 32'h1111_1111, 1'b1, 3'd2, 32'h200, 32'h2222_2222);
        xfer(0, 1'b0, 3'd2, 32'h200, 32'h0);
        dual(1'b1, 3'd2, 32'h200, 32'hAAAA_AAAA, 1'b1, 3'd0, 32'h201, 32'h0000_BB00);
        xfer(0, 1'b0, 3'd2, 32'h200, 32'h0);
        dual(1'b0, 3'd2, 32'h200, 32'h0, 1'b1, 3'd2, 32'h200, 32'h3333_3333);
        xfer(1, 1'b0, 3'd2, 32'h200, 32'h0);

        // Random wait states from the LFSR
        stall_mode[0] = 2'd2;
        stall_val[0] = 4'hF;
        for (int i = 0; i < 1000; i++) xfer(0, 1'b0, 3'd2, 32'h200, 32'h0);
        stall_mode[1] = 2'd2;
        stall_val[1] = 4'h5;
        for (int i = 0; i < 20; i++) xfer(1, 1'b0, 3'd2, 32'h100, 32'h0);
        stall_mode = '0;

        // Reset in the middle of a stalled write: no commit, IDLE next cycle
        xfer(0, 1'b1, 3'd2, 32'h300, 32'h1234_5678);
        stall_mode[0] = 2'd1;
        stall_val[0] = 4'd5;
        q0.push_back('{wr: 1'b1, err: 1'b0, waits: 5, data: 32'h0});
        drive_addr(0, 1'b1, 3'd2, 32'h300);
        step();
        bus.htrans[0] = 2'b00;
        bus.hwdata[0] = 32'hFFFF_FFFF;
        step();
        step();
        chk("pre_rst_hready", 32'(bus.hready[0]), 32'd0);
        rst = 1'b1;
        step();
        chk("mid_rst_hready", 32'(bus.hready[0]), 32'd1);
        chk("mid_rst_hresp", 32'(bus.hresp[0]), 32'd0);
        rst = 1'b0;
        stall_mode = '0;
        for (int p = 0; p < NP; p++) lfsr_m[p] = 16'hACE1 ^ 16'(p);
        step();
        xfer(0, 1'b0, 3'd2, 32'h300, 32'h0);

        step();
        chk("queues_drained", 32'(q0.size() + q1.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
